call_stack: RTL and testbench
=============================

CALL_STACK -- requirements
Module: call_stack

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the return-address width, matching the PC width.
REQ-002 Parameter DEPTH, default 8, SHALL set the number of stack entries; it SHALL be a power of two, minimum 2.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 push  input  1  SHALL request a store of din on CALL.
REQ-006 pop  input  1  SHALL request removal of the top entry on RET; it is driven by the same signal as the PC's STACK_POP.
REQ-007 din  input  WIDTH  SHALL carry the return address to store, i.e. the current PC value.
REQ-008 dout  output  WIDTH  SHALL carry the top-of-stack entry and feed the PC load input.
REQ-009 empty  output  1  SHALL be high when count == 0.
REQ-010 full  output  1  SHALL be high when count == DEPTH.
REQ-011 count  output  clog2(DEPTH)+1  SHALL carry the current occupancy.
REQ-012 err_ovf, err_unf  output  1 each  SHALL be the sticky overflow and underflow flags (see Configuration).

Function
REQ-013 The block SHALL be a LIFO: an entry array plus a stack pointer sp equal to count.
REQ-014 dout SHALL be combinational from registered state: mem[sp-1] when not empty, all-zero when empty.
REQ-015 dout SHALL therefore be valid in the cycle pop is asserted, so the PC loads it on the same edge; the PC adds 1.
REQ-016 push only, not full: mem[sp] <= din; sp <= sp+1.
REQ-017 pop only, not empty: sp <= sp-1; memory is unchanged.
REQ-018 push and pop together, not empty: mem[sp-1] <= din; sp is unchanged (top replaced). This applies even when full.
REQ-019 push and pop together, empty: treated as push only; no underflow is flagged.
REQ-020 push only, full: ignored, state unchanged; err_ovf SHALL set.
REQ-021 pop only, empty: ignored, sp stays 0 and dout stays 0; err_unf SHALL set.
REQ-022 Neither request asserted: the block SHALL hold all state.
REQ-023 Pointer arithmetic SHALL never wrap; count SHALL stay in the range 0..DEPTH.
REQ-024 Latency: a pushed value SHALL appear on dout in the cycle after the push edge.

Reset
REQ-025 On rst low, the block SHALL immediately force sp=0, empty=1, full=0, count=0, dout=0, err_ovf=0 and err_unf=0, including when reset occurs mid-sequence.
REQ-026 Memory contents SHALL NOT be reset; they are unobservable while empty.
REQ-027 The first edge after rst rises SHALL act normally.

Configuration
REQ-028 With macro CALL_STACK_ERR_EN defined, err_ovf and err_unf SHALL be sticky and clear only on reset.
REQ-029 With CALL_STACK_ERR_EN undefined, err_ovf and err_unf SHALL be tied to 0 and no flag registers SHALL exist.
REQ-030 Ignore behaviour on full or empty SHALL be identical in both configurations.

Structure
REQ-031 The shared package gpp_pkg SHALL hold ADDR_W=16, CALL_STACK_DEPTH=8 and the push/pop operation encoding used by the control unit.
REQ-032 The block SHALL be a single module; the entry array SHALL be inline, with no sub-module.

Verification
REQ-033 Reset, then hold idle: the bench SHALL see empty=1, count=0, dout=0 and both error flags 0.
REQ-034 Push 0x6AB3, then push 0x87AB: the bench SHALL see count=2, dout=0x87AB; after one pop, dout=0x6AB3 and count=1.
REQ-035 With count=1 and top 0x6AB3, assert push=1 and pop=1 with din=0x8400: the bench SHALL see count=1, dout=0x8400.
REQ-036 Push DEPTH distinct values, then push 0xFFFF: the bench SHALL see full=1, count=DEPTH, the top unchanged, and err_ovf=1 when the macro is defined, else 0.
REQ-037 Pop when empty: the bench SHALL see count=0, dout=0, and err_unf=1 when the macro is defined, else 0.
REQ-038 Drive rst low between clock edges with count=3: the bench SHALL see outputs go to reset values before the next edge, and a following push of 0x0001 SHALL give count=1, dout=0x0001.

Source files
------------

// File: rtl/gpp_pkg.sv
//------------------------------------------------------------------------------
// Module   : gpp_pkg
// Purpose  : Shared definitions for the general-purpose processor datapath:
//            PC / return-address width, call-stack depth and the push/pop
//            operation encoding driven by the control unit.
// Ports    : none (package)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package gpp_pkg;

    localparam int ADDR_W           = 16;
    localparam int CALL_STACK_DEPTH = 8;

    // Encoding is simply {push, pop}, so the control unit can drive the two
    // strobes directly and the stack can decode them as one operation.
    typedef enum logic [1:0] {
        STK_IDLE    = 2'b00,
        STK_POP     = 2'b01,
        STK_PUSH    = 2'b10,
        STK_REPLACE = 2'b11
    } stack_op_e;

    function automatic stack_op_e stack_op(input logic push, input logic pop);
        return stack_op_e'({push, pop});
    endfunction

endpackage

`default_nettype wire

// File: rtl/call_stack.sv
//------------------------------------------------------------------------------
// Module   : call_stack
// Purpose  : LIFO return-address stack for CALL/RET. The top entry is
//            presented combinationally on dout so the PC can load it on the
//            same edge that pop is asserted.
// Ports    : clk      - single clock, rising edge
//            rst      - asynchronous, active-low reset
//            push     - store din (CALL)
//            pop      - remove top entry (RET, shared with PC STACK_POP)
//            din      - return address to store
//            dout     - top-of-stack entry, zero when empty
//            empty    - count == 0
//            full     - count == DEPTH
//            count    - current occupancy, 0..DEPTH
//            err_ovf  - sticky overflow flag (push on full)
//            err_unf  - sticky underflow flag (pop on empty)
// Options  : CALL_STACK_ERR_EN - when defined, err_ovf/err_unf are sticky
//            registers cleared only by reset; otherwise both are tied to 0.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module call_stack
    import gpp_pkg::*;
#(
    parameter int WIDTH = ADDR_W,
    parameter int DEPTH = CALL_STACK_DEPTH   // power of two, >= 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err_ovf,
    output logic                     err_unf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    sp;
    logic [CW-1:0]    sp_next;
    logic [CW-1:0]    sp_dec;
    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    wr_idx;
    logic             wr_en;
    stack_op_e        op;

    assign op      = stack_op(push, pop);
    assign sp_dec  = sp - CW'(1);
    assign top_idx = sp_dec[AW-1:0];
    assign empty   = (sp == '0);
    assign full    = (sp == CW'(DEPTH));
    assign count   = sp;
    // Empty masks whatever stale data sits in the unreset array.
    assign dout    = empty ? '0 : mem[top_idx];

    always_comb begin
        sp_next = sp;
        wr_en   = 1'b0;
        wr_idx  = sp[AW-1:0];
        case (op)
            STK_PUSH: begin
                if (!full) begin
                    wr_en   = 1'b1;
                    sp_next = sp + CW'(1);
                end
            end
            STK_POP: begin
                if (!empty) begin
                    sp_next = sp_dec;
                end
            end
            STK_REPLACE: begin
                // Simultaneous RET+CALL overwrites the top in place (also when
                // full); on an empty stack it degenerates to a plain push.
                wr_en = 1'b1;
                if (empty) begin
                    sp_next = sp + CW'(1);
                end else begin
                    wr_idx = top_idx;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp <= '0;
        end else begin
            sp <= sp_next;
        end
    end

    // Storage is deliberately not reset; it is invisible while empty.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= din;
        end
    end

`ifdef CALL_STACK_ERR_EN
    logic ovf_flag;
    logic unf_flag;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_flag <= 1'b0;
            unf_flag <= 1'b0;
        end else begin
            if (op == STK_PUSH && full) begin
                ovf_flag <= 1'b1;
            end
            if (op == STK_POP && empty) begin
                unf_flag <= 1'b1;
            end
        end
    end

    assign err_ovf = ovf_flag;
    assign err_unf = unf_flag;
`else
    assign err_ovf = 1'b0;
    assign err_unf = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_call_stack.sv
//------------------------------------------------------------------------------
// Module   : tb_call_stack
// Purpose  : Scoreboard bench for call_stack. A queue-based reference model
//            predicts the outputs after every clock edge; a monitor compares
//            them against the DUT on the falling edge.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_call_stack;

    localparam int WIDTH = 16;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

`ifdef CALL_STACK_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic             clk  = 1'b0;
    logic             rst  = 1'b0;
    logic             push = 1'b0;
    logic             pop  = 1'b0;
    logic [WIDTH-1:0] din  = '0;
    logic [WIDTH-1:0] dout;
    logic             empty;
    logic             full;
    logic [CW-1:0]    count;
    logic             err_ovf;
    logic             err_unf;

    call_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .din     (din),
        .dout    (dout),
        .empty   (empty),
        .full    (full),
        .count   (count),
        .err_ovf (err_ovf),
        .err_unf (err_unf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CW-1:0]    count;
        logic [WIDTH-1:0] dout;
        logic             empty;
        logic             full;
        logic             ovf;
        logic             unf;
    } exp_t;

    exp_t             exp_q[$];
    logic [WIDTH-1:0] model[$];
    bit               m_ovf = 1'b0;
    bit               m_unf = 1'b0;
    int               checks = 0;
    int               errors = 0;

    function automatic exp_t snapshot();
        exp_t e;
        e.count = CW'(model.size());
        e.dout  = (model.size() > 0) ? model[model.size()-1] : '0;
        e.empty = (model.size() == 0);
        e.full  = (model.size() == DEPTH);
        e.ovf   = ERR_EN ? m_ovf : 1'b0;
        e.unf   = ERR_EN ? m_unf : 1'b0;
        return e;
    endfunction

    // Behavioural LIFO: a queue whose back is the top of stack.
    task automatic model_apply(input bit p, input bit q, input logic [WIDTH-1:0] d);
        if (p && q && model.size() > 0) begin
            model[model.size()-1] = d;
        end else if (p) begin
            if (model.size() < DEPTH) model.push_back(d);
            else                      m_ovf = 1'b1;
        end else if (q) begin
            if (model.size() > 0) void'(model.pop_back());
            else                  m_unf = 1'b1;
        end
    endtask

    task automatic model_reset();
        model.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all(input exp_t e, input string tag);
        check({tag, ".count"},   32'(count),   32'(e.count));
        check({tag, ".dout"},    32'(dout),    32'(e.dout));
        check({tag, ".empty"},   32'(empty),   32'(e.empty));
        check({tag, ".full"},    32'(full),    32'(e.full));
        check({tag, ".err_ovf"}, 32'(err_ovf), 32'(e.ovf));
        check({tag, ".err_unf"}, 32'(err_unf), 32'(e.unf));
    endtask

    // Drive one cycle of stimulus and queue the expected post-edge state.
    task automatic step(input bit p, input bit q, input logic [WIDTH-1:0] d);
        @(negedge clk);
        push = p;
        pop  = q;
        din  = d;
        @(posedge clk);
        model_apply(p, q, d);
        exp_q.push_back(snapshot());
    endtask

    // Monitor: outputs depend only on registered state, so the falling edge
    // is a stable sampling point for the prediction of the last rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                compare_all(e, "scb");
            end
        end
    end

    initial begin
        int bias;

        // Reset asserted from time zero.
        #1;
        compare_all(snapshot(), "reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Idle after reset.
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);

        // Two pushes, then one pop.
        step(1'b1, 1'b0, 16'h6AB3);
        step(1'b1, 1'b0, 16'h87AB);
        step(1'b0, 1'b1, '0);

        // Simultaneous push+pop replaces the top.
        step(1'b1, 1'b1, 16'h8400);

        // Drain, then fill to DEPTH and overflow.
        step(1'b0, 1'b1, '0);
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 1'b0, WIDTH'(16'h1000 + i * 16'h0111));
        end
        step(1'b1, 1'b0, 16'hFFFF);
        step(1'b0, 1'b0, '0);

        // Replace while full, then drain and underflow.
        step(1'b1, 1'b1, 16'h2222);
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b1, '0);
        end
        step(1'b0, 1'b1, '0);
        step(1'b1, 1'b1, 16'h5A5A);   // push+pop on empty acts as push
        step(1'b0, 1'b1, '0);

        // Asynchronous reset between edges with three entries stacked.
        step(1'b1, 1'b0, 16'h0A0A);
        step(1'b1, 1'b0, 16'h0B0B);
        step(1'b1, 1'b0, 16'h0C0C);
        step(1'b0, 1'b0, '0);
        @(negedge clk);
        push = 1'b0;
        pop  = 1'b0;
        #1;
        rst = 1'b0;
        model_reset();
        #1;
        compare_all(snapshot(), "async_reset");
        #1;
        rst = 1'b1;
        step(1'b1, 1'b0, 16'h0001);
        step(1'b0, 1'b0, '0);

        // Randomised phases alternating push-heavy and pop-heavy traffic.
        for (int blk = 0; blk < 10; blk++) begin
            bias = (blk % 2 == 0) ? 75 : 25;
            for (int i = 0; i < 40; i++) begin
                step(($urandom_range(0, 99) < bias),
                     ($urandom_range(0, 99) < (100 - bias)),
                     WIDTH'($urandom));
            end
        end

        @(negedge clk);
        push = 1'b0;
        pop  = 1'b0;
        repeat (2) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
